// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: transmitter FSM states, bit timing constants,
// per-frame line settings and small helpers used by the TX engine.
package uart_tx_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // 16x oversampling: every serial bit lasts this many baud ticks.
    localparam int unsigned TICKS_PER_BIT = 16;
    localparam logic [4:0]  BIT_LAST_TICK = 5'(TICKS_PER_BIT - 1);

    // Interrupt identification code reported for "THR empty".
    localparam logic [3:0]  THRE_IID = 4'b0010;

    // Line settings captured at the start of each frame.
    typedef struct packed {
        logic [1:0] dls;
        logic       stop;
        logic       pen;
        logic       eps;
    } frame_cfg_t;

    // Index of the last tick of the stop phase: 1, 1.5 or 2 stop bits.
    function automatic logic [4:0] stop_last_tick(input logic [1:0] dls, input logic stop);
        if (!stop)
            return 5'd15;
        else if (dls == 2'b00)
            return 5'd23;
        else
            return 5'd31;
    endfunction

    // Parity over the 5+dls valid data bits. Even parity (eps=1) makes the
    // total count of ones even, so the bit is the plain XOR; odd inverts it.
    function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] dls,
                                          input logic eps);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - dls);
        return (^(data & mask)) ^ ~eps;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Register-block <-> TX engine signal bundle. The register block is the
// master (drives line/divisor/THR settings), the TX engine is the slave.
interface uart_tx_engine_if;

    logic [15:0] reg_ctrl_dllh_data;
    logic        reg_ctrl_set_dllh_vld;
    logic [1:0]  reg_ctrl_lcr_dls;
    logic        reg_ctrl_lcr_stop;
    logic        reg_ctrl_lcr_pen;
    logic        reg_ctrl_lcr_eps;
    logic        reg_ctrl_thr_vld;
    logic [7:0]  reg_ctrl_thr_data;
    logic [2:0]  reg_ctrl_ier_enable;
    logic        reg_ctrl_threint_en;

    logic        ctrl_reg_thr_read;
    logic        ctrl_reg_thsr_empty;
    logic        ctrl_reg_busy;
    logic        tx_iid_vld;
    logic [3:0]  tx_iid;

    modport master (
        output reg_ctrl_dllh_data, reg_ctrl_set_dllh_vld, reg_ctrl_lcr_dls,
               reg_ctrl_lcr_stop, reg_ctrl_lcr_pen, reg_ctrl_lcr_eps,
               reg_ctrl_thr_vld, reg_ctrl_thr_data, reg_ctrl_ier_enable,
               reg_ctrl_threint_en,
        input  ctrl_reg_thr_read, ctrl_reg_thsr_empty, ctrl_reg_busy,
               tx_iid_vld, tx_iid
    );

    modport slave (
        input  reg_ctrl_dllh_data, reg_ctrl_set_dllh_vld, reg_ctrl_lcr_dls,
               reg_ctrl_lcr_stop, reg_ctrl_lcr_pen, reg_ctrl_lcr_eps,
               reg_ctrl_thr_vld, reg_ctrl_thr_data, reg_ctrl_ier_enable,
               reg_ctrl_threint_en,
        output ctrl_reg_thr_read, ctrl_reg_thsr_empty, ctrl_reg_busy,
               tx_iid_vld, tx_iid
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Baud generator: counts 0..divisor-1 and emits a one-cycle 16x tick at the
// wrap. A divisor of zero stops the tick; a divisor write restarts the count.
module uart_baud_gen (
    input  logic        sys_clk,
    input  logic        rst_b,
    input  logic [15:0] divisor_i,
    input  logic        clear_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // Next count and tick; '>=' lets a smaller divisor written mid-count wrap
    // on the very next cycle instead of running up to 65535.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        cnt_d  = cnt_q + 16'd1;
        tick_d = 1'b0;
        if (divisor_i == 16'd0) begin
            cnt_d = '0;
        end else if (cnt_q >= divisor_i - 16'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
        if (clear_i)
            cnt_d = '0;
    end

    // Counter and registered tick.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (!rst_b) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises the holding-register byte as start, 5..8 data
// bits LSB first, optional parity and 1/1.5/2 stop bits, timed by 16x ticks.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
(
    input  logic            sys_clk,
    input  logic            rst_b,
    uart_tx_engine_if.slave reg_if,
    output logic            baud_tick16,
    output logic            uart_txd
);

    tx_state_e  state_q;
    logic [4:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    frame_cfg_t cfg_q;
    logic       parity_q;
    logic       txd_q;
    logic       thr_read_q;

    logic       div_nz;
    logic       bit_done;
    logic       stop_done;
    logic [2:0] last_bit;
    logic       start_frame;
    logic [1:0] unused_ier;

    uart_baud_gen u_baud_gen (
        .sys_clk   (sys_clk),
        .rst_b     (rst_b),
        .divisor_i (reg_if.reg_ctrl_dllh_data),
        .clear_i   (reg_if.reg_ctrl_set_dllh_vld),
        .tick_o    (baud_tick16)
    );

    // Bit-phase decode; a new frame may start from IDLE or straight out of STOP.
    always_comb begin
        div_nz      = |reg_if.reg_ctrl_dllh_data;
        bit_done    = baud_tick16 && (tick_cnt_q == BIT_LAST_TICK);
        stop_done   = baud_tick16 && (tick_cnt_q == stop_last_tick(cfg_q.dls, cfg_q.stop));
        last_bit    = 3'd4 + {1'b0, cfg_q.dls};
        start_frame = reg_if.reg_ctrl_thr_vld && div_nz &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_done));
    end

    // Transmit FSM with registered line output and THR-consumed pulse.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cfg_q      <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            thr_read_q <= 1'b0;
        end else begin
            thr_read_q <= 1'b0;
            if (start_frame) begin
                state_q    <= ST_START;
                txd_q      <= 1'b0;
                thr_read_q <= 1'b1;
                shift_q    <= reg_if.reg_ctrl_thr_data;
                cfg_q      <= '{dls:  reg_if.reg_ctrl_lcr_dls,
                                stop: reg_if.reg_ctrl_lcr_stop,
                                pen:  reg_if.reg_ctrl_lcr_pen,
                                eps:  reg_if.reg_ctrl_lcr_eps};
                parity_q   <= frame_parity(reg_if.reg_ctrl_thr_data,
                                           reg_if.reg_ctrl_lcr_dls,
                                           reg_if.reg_ctrl_lcr_eps);
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else if (baud_tick16) begin
                tick_cnt_q <= tick_cnt_q + 5'd1;
                case (state_q)
                    ST_IDLE: begin
                        tick_cnt_q <= '0;
                    end
                    ST_START: begin
                        if (bit_done) begin
                            state_q    <= ST_DATA;
                            tick_cnt_q <= '0;
                            txd_q      <= shift_q[0];
                        end
                    end
                    ST_DATA: begin
                        if (bit_done) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_q >> 1;
                            if (bit_cnt_q == last_bit) begin
                                state_q <= cfg_q.pen ? ST_PARITY : ST_STOP;
                                txd_q   <= cfg_q.pen ? parity_q : 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                txd_q     <= shift_q[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_done) begin
                            state_q    <= ST_STOP;
                            tick_cnt_q <= '0;
                            txd_q      <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (stop_done) begin
                            state_q    <= ST_IDLE;
                            tick_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        tick_cnt_q <= '0;
                        txd_q      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign uart_txd                   = txd_q;
    assign reg_if.ctrl_reg_thr_read   = thr_read_q;
    assign reg_if.ctrl_reg_busy       = (state_q != ST_IDLE);
    assign reg_if.ctrl_reg_thsr_empty = (state_q == ST_IDLE);
    assign reg_if.tx_iid              = THRE_IID;
    // Both THRE causes in one cycle merge into a single pulse.
    assign reg_if.tx_iid_vld          = reg_if.reg_ctrl_ier_enable[1] &
                                        (thr_read_q | (reg_if.reg_ctrl_threint_en &
                                                       ~reg_if.reg_ctrl_thr_vld));
    assign unused_ier                 = {reg_if.reg_ctrl_ier_enable[2],
                                         reg_if.reg_ctrl_ier_enable[0]};

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a host model feeds the holding
// register from a byte queue, expected frames go to a scoreboard queue and
// a receiver task decodes uart_txd against them.
module tb_uart_tx_engine;
    import uart_tx_engine_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [1:0] dls;
        logic       pen;
        logic       eps;
        logic       stop;
        int         div;
    } frame_t;

    typedef struct {
        logic [2:0] ier;
        logic       threint;
        logic       vld;
        logic       exp_iid;
    } irq_vec_t;

    logic sys_clk = 1'b0;
    logic rst_b   = 1'b0;
    logic baud_tick16;
    logic uart_txd;

    uart_tx_engine_if bus ();

    uart_tx_engine dut (
        .sys_clk     (sys_clk),
        .rst_b       (rst_b),
        .reg_if      (bus),
        .baud_tick16 (baud_tick16),
        .uart_txd    (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] host_q[$];
    frame_t     exp_q[$];

    logic s_txd, s_read, s_busy, s_empty, s_iid, s_tick;
    int   read_cnt = 0;
    int   tick_cnt = 0;
    int   iid_cnt  = 0;
    int   dls_switch_at = -1;
    logic [1:0] dls_switch_val = 2'd0;

    frame_t   ftab[5];
    irq_vec_t itab[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_thr();
        bus.reg_ctrl_thr_vld  = (host_q.size() != 0);
        bus.reg_ctrl_thr_data = (host_q.size() != 0) ? host_q[0] : 8'h00;
    endtask

    // One clock: sample outputs on the falling edge, then let the host react.
    task automatic step();
        @(negedge sys_clk);
        s_txd   = uart_txd;
        s_read  = bus.ctrl_reg_thr_read;
        s_busy  = bus.ctrl_reg_busy;
        s_empty = bus.ctrl_reg_thsr_empty;
        s_iid   = bus.tx_iid_vld;
        s_tick  = baud_tick16;
        tick_cnt += int'(s_tick);
        iid_cnt  += int'(s_iid);
        if (s_read) begin
            read_cnt++;
            if (host_q.size() != 0) void'(host_q.pop_front());
            if (read_cnt == dls_switch_at) bus.reg_ctrl_lcr_dls = dls_switch_val;
        end
        drive_thr();
    endtask

    task automatic set_div(input int d);
        bus.reg_ctrl_dllh_data    = 16'(d);
        bus.reg_ctrl_set_dllh_vld = 1'b1;
        step();
        bus.reg_ctrl_set_dllh_vld = 1'b0;
        step();
    endtask

    task automatic set_lcr(input frame_t f);
        bus.reg_ctrl_lcr_dls  = f.dls;
        bus.reg_ctrl_lcr_stop = f.stop;
        bus.reg_ctrl_lcr_pen  = f.pen;
        bus.reg_ctrl_lcr_eps  = f.eps;
    endtask

    task automatic push_frame(input frame_t f);
        host_q.push_back(f.data);
        exp_q.push_back(f);
        drive_thr();
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            step();
            n++;
        end while (s_busy !== 1'b0 && n < 1000);
        check("wait for idle", 32'(s_busy), 0);
    endtask

    // Expected line level of bit k of a frame (0 = start bit).
    function automatic logic exp_bit(input frame_t f, input int k);
        int n    = 5 + int'(f.dls);
        int ones = 0;
        if (k == 0) return 1'b0;
        if (k <= n) return f.data[k-1];
        if (f.pen && k == n + 1) begin
            for (int i = 0; i < n; i++) ones += int'(f.data[i]);
            return f.eps ? 1'(ones % 2) : 1'(1 - (ones % 2));
        end
        return 1'b1;
    endfunction

    function automatic int stop_len(input frame_t f);
        if (!f.stop) return 16;
        return (f.dls == 2'd0) ? 24 : 32;
    endfunction

    // Receive one frame and compare it with the oldest scoreboard entry.
    task automatic rx_frame(output int waited);
        frame_t f;
        int n, p, nb, len, end_c, mism, k;
        waited = 0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected frame queued");
            return;
        end
        f = exp_q.pop_front();
        do begin
            step();
            waited++;
        end while (s_txd !== 1'b0 && waited < 200);
        if (s_txd !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start bit timeout: frame %02h never started", f.data);
            return;
        end
        n     = 5 + int'(f.dls);
        p     = int'(f.pen);
        nb    = 1 + n + p;
        len   = 16 * nb + stop_len(f);
        end_c = (f.div == 1) ? len - 1 : 8 * f.div + 16 * f.div * nb;
        mism  = 0;
        check($sformatf("frame %02h thr_read at start", f.data), 32'(s_read), 1);
        for (int c = 0; c <= end_c; c++) begin
            if (c > 0) step();
            if (f.div == 1) begin
                k = (c < 16 * nb) ? c / 16 : nb;
                if (s_txd !== exp_bit(f, k) || s_busy !== 1'b1 || s_empty !== 1'b0) mism++;
            end
            if (c >= 8 * f.div && (c - 8 * f.div) % (16 * f.div) == 0) begin
                k = (c - 8 * f.div) / (16 * f.div);
                check($sformatf("frame %02h bit%0d", f.data, k), 32'(s_txd), 32'(exp_bit(f, k)));
            end
        end
        if (f.div == 1) check($sformatf("frame %02h waveform", f.data), mism, 0);
    endtask

    initial begin
        int w, w2, r0, i0, t0, mism, n;

        ftab[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1};
        ftab[1] = '{8'h03, 2'd2, 1'b1, 1'b1, 1'b0, 2};
        ftab[2] = '{8'h1A, 2'd0, 1'b0, 1'b0, 1'b1, 1};
        ftab[3] = '{8'hA7, 2'd1, 1'b1, 1'b1, 1'b1, 1};
        ftab[4] = '{8'hFF, 2'd3, 1'b1, 1'b1, 1'b0, 3};

        itab[0] = '{3'b010, 1'b1, 1'b0, 1'b1};
        itab[1] = '{3'b010, 1'b1, 1'b1, 1'b0};
        itab[2] = '{3'b000, 1'b1, 1'b0, 1'b0};
        itab[3] = '{3'b101, 1'b1, 1'b0, 1'b0};
        itab[4] = '{3'b010, 1'b0, 1'b0, 1'b0};

        bus.reg_ctrl_dllh_data    = 16'd0;
        bus.reg_ctrl_set_dllh_vld = 1'b0;
        bus.reg_ctrl_lcr_dls      = 2'd3;
        bus.reg_ctrl_lcr_stop     = 1'b0;
        bus.reg_ctrl_lcr_pen      = 1'b0;
        bus.reg_ctrl_lcr_eps      = 1'b0;
        bus.reg_ctrl_ier_enable   = 3'b000;
        bus.reg_ctrl_threint_en   = 1'b0;
        drive_thr();

        // Reset state
        repeat (3) step();
        check("reset txd", 32'(s_txd), 1);
        check("reset busy", 32'(s_busy), 0);
        check("reset thsr_empty", 32'(s_empty), 1);
        check("reset thr_read", 32'(s_read), 0);
        check("reset tx_iid_vld", 32'(s_iid), 0);
        check("reset baud_tick16", 32'(s_tick), 0);
        check("tx_iid code", 32'(bus.tx_iid), 32'h2);
        rst_b = 1'b1;

        // Baud tick rate for divisors 0, 1 and 4
        repeat (2) step();
        t0 = tick_cnt;
        repeat (20) step();
        check("ticks div=0", tick_cnt - t0, 0);
        set_div(1);
        t0 = tick_cnt;
        repeat (20) step();
        check("ticks div=1", tick_cnt - t0, 20);
        set_div(4);
        step();
        t0 = tick_cnt;
        repeat (40) step();
        check("ticks div=4", tick_cnt - t0, 10);

        // THRE interrupt request combinations (divisor 0: no frame can start)
        set_div(0);
        foreach (itab[i]) begin
            bus.reg_ctrl_ier_enable = itab[i].ier;
            bus.reg_ctrl_threint_en = itab[i].threint;
            host_q.delete();
            if (itab[i].vld) host_q.push_back(8'h00);
            drive_thr();
            #1;
            check($sformatf("iid vec%0d", i), 32'(bus.tx_iid_vld), 32'(itab[i].exp_iid));
        end
        host_q.delete();
        bus.reg_ctrl_threint_en = 1'b0;
        bus.reg_ctrl_ier_enable = 3'b010;
        drive_thr();
        step();

        // Table of single frames
        foreach (ftab[i]) begin
            wait_idle();
            set_div(ftab[i].div);
            set_lcr(ftab[i]);
            r0 = read_cnt;
            i0 = iid_cnt;
            push_frame(ftab[i]);
            rx_frame(w);
            check($sformatf("frame %02h thr_read count", ftab[i].data), read_cnt - r0, 1);
            check($sformatf("frame %02h iid pulses", ftab[i].data), iid_cnt - i0, 1);
            if (ftab[i].div == 1) begin
                step();
                check($sformatf("frame %02h busy after stop", ftab[i].data), 32'(s_busy), 0);
                check($sformatf("frame %02h empty after stop", ftab[i].data), 32'(s_empty), 1);
            end
        end

        // Back-to-back frames: no idle gap between stop and next start
        wait_idle();
        set_div(1);
        set_lcr(ftab[0]);
        r0 = read_cnt;
        push_frame('{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1});
        push_frame('{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1});
        rx_frame(w);
        rx_frame(w2);
        check("b2b start follows stop", w2, 1);
        check("b2b thr_read count", read_cnt - r0, 2);
        step();
        check("b2b busy after second frame", 32'(s_busy), 0);

        // Data length change after the first frame has latched its settings
        wait_idle();
        bus.reg_ctrl_lcr_dls  = 2'd3;
        bus.reg_ctrl_lcr_pen  = 1'b0;
        bus.reg_ctrl_lcr_stop = 1'b0;
        dls_switch_at  = read_cnt + 1;
        dls_switch_val = 2'd0;
        push_frame('{8'hB6, 2'd3, 1'b0, 1'b0, 1'b0, 1});
        push_frame('{8'h4D, 2'd0, 1'b0, 1'b0, 1'b0, 1});
        rx_frame(w);
        rx_frame(w2);
        check("dls change next frame back-to-back", w2, 1);
        dls_switch_at = -1;
        bus.reg_ctrl_lcr_dls = 2'd3;

        // Reset asserted during DATA, then released with divisor 0
        wait_idle();
        host_q.push_back(8'h00);
        drive_thr();
        n = 0;
        do begin
            step();
            n++;
        end while (s_busy !== 1'b1 && n < 100);
        check("reset test frame started", 32'(s_busy), 1);
        repeat (40) step();
        check("pre-reset txd in DATA", 32'(s_txd), 0);
        #2;
        rst_b = 1'b0;
        bus.reg_ctrl_dllh_data = 16'd0;
        #1;
        check("async reset txd", 32'(uart_txd), 1);
        check("async reset busy", 32'(bus.ctrl_reg_busy), 0);
        check("async reset thsr_empty", 32'(bus.ctrl_reg_thsr_empty), 1);
        host_q.delete();
        host_q.push_back(8'h00);
        drive_thr();
        repeat (3) step();
        rst_b = 1'b1;
        t0 = tick_cnt;
        r0 = read_cnt;
        mism = 0;
        repeat (60) begin
            step();
            if (s_txd !== 1'b1 || s_busy !== 1'b0) mism++;
        end
        check("post-reset ticks div=0", tick_cnt - t0, 0);
        check("post-reset thr_read", read_cnt - r0, 0);
        check("post-reset line idle", mism, 0);
        host_q.delete();
        drive_thr();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
